// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: frame-builder state encoding, preamble length and
// the default preamble sign masks that the RX correlators also reference.
package ofdm_pkg;

    localparam int PREAMBLE_LEN = 256;
    localparam int PRE_IDX_W    = $clog2(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE_A   = 3'd1,
        S_PRE_B   = 3'd2,
        S_PAYLOAD = 3'd3,
        S_GAP     = 3'd4
    } ofdm_state_e;

    // Flat constants keep the legacy state-register encoding visible.
    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_PRE_A   = S_PRE_A;
    localparam logic [2:0] ST_PRE_B   = S_PRE_B;
    localparam logic [2:0] ST_PAYLOAD = S_PAYLOAD;
    localparam logic [2:0] ST_GAP     = S_GAP;

    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_A_I_DEF =
        256'hA5C3_96F0_1E2D_3C4B_5A69_7887_96A5_B4C3_D2E1_F00F_1E2D_3C4B_5A69_7887_96A5_B4C3;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_A_Q_DEF =
        256'h3C5A_E1D2_0F96_87B4_C3A5_6978_4B2D_1EF0_9A6C_35E8_71D4_B20F_8E63_5CA1_47F9_D03B;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_B_I_DEF =
        256'h6E2B_9D14_F7A0_53C8_1B8E_4D72_A6F3_0C59_E28D_7B16_C4A9_3F50_952E_D86B_01C7_4AF3;
    localparam logic [PREAMBLE_LEN-1:0] PREAMBLE_B_Q_DEF =
        256'hD17A_0E5C_B3F8_6294_7C2D_E9A1_5F06_B48B_23E7_9D5A_C160_F8B4_4A9E_07D3_6B25_E1C8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ofdm_frame_tx_if.sv
// Sample stream bundle of ofdm_frame_tx: payload input handshake and the
// registered DAC-side output. slave = frame builder, master = its environment.
interface ofdm_frame_tx_if #(
    parameter int DATA_SIZE = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data_i;
    logic [DATA_SIZE-1:0] in_data_q;
    logic                 out_valid;
    logic [DATA_SIZE-1:0] out_data_i;
    logic [DATA_SIZE-1:0] out_data_q;

    modport slave (
        input  in_valid, in_data_i, in_data_q,
        output in_ready, out_valid, out_data_i, out_data_q
    );

    modport master (
        output in_valid, in_data_i, in_data_q,
        input  in_ready, out_valid, out_data_i, out_data_q
    );
endinterface

// File: rtl/ofdm_preamble_gen.sv
// Preamble sample source: picks mask A or B at bit idx and registers the
// corresponding +/-AMP I/Q pair.
module ofdm_preamble_gen
    import ofdm_pkg::*;
#(
    parameter int                      DATA_SIZE    = 16,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_A_I = PREAMBLE_A_I_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_A_Q = PREAMBLE_A_Q_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_B_I = PREAMBLE_B_I_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_B_Q = PREAMBLE_B_Q_DEF,
    parameter int                      AMP          = 2**(DATA_SIZE-2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 sel_b,
    input  logic [PRE_IDX_W-1:0] idx,
    output logic [DATA_SIZE-1:0] pre_i,
    output logic [DATA_SIZE-1:0] pre_q
);
    localparam logic [DATA_SIZE-1:0] POS_AMP = DATA_SIZE'(AMP);
    localparam logic [DATA_SIZE-1:0] NEG_AMP = DATA_SIZE'(-AMP);

    logic bit_i;
    logic bit_q;

    always_comb begin
        bit_i = sel_b ? PREAMBLE_B_I[idx] : PREAMBLE_A_I[idx];
        bit_q = sel_b ? PREAMBLE_B_Q[idx] : PREAMBLE_A_Q[idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_i <= '0;
            pre_q <= '0;
        end else if (load) begin
            pre_i <= bit_i ? POS_AMP : NEG_AMP;
            pre_q <= bit_q ? POS_AMP : NEG_AMP;
        end
    end

endmodule

// File: rtl/ofdm_frame_tx.sv
// OFDM TX frame builder: preamble A, preamble B, then PAYLOAD_LEN streamed samples.
// Define OFDM_FRAME_TX_GAP_EN to append GAP_LEN zero samples before returning to idle.
module ofdm_frame_tx
    import ofdm_pkg::*;
#(
    parameter int                      DATA_SIZE    = 16,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_A_I = PREAMBLE_A_I_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_A_Q = PREAMBLE_A_Q_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_B_I = PREAMBLE_B_I_DEF,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE_B_Q = PREAMBLE_B_Q_DEF,
    parameter int                      AMP          = 2**(DATA_SIZE-2),
    parameter int                      PAYLOAD_LEN  = 1024,
    parameter int                      GAP_LEN      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            start,
    ofdm_frame_tx_if.slave  s,
    output logic            busy,
    output logic            o_frame_done
);
    localparam int CNT_W = $clog2(max3(PREAMBLE_LEN, PAYLOAD_LEN, GAP_LEN));

    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic                 out_valid_r;
    logic                 out_sel_pre;
    logic [DATA_SIZE-1:0] pay_i;
    logic [DATA_SIZE-1:0] pay_q;
    logic [DATA_SIZE-1:0] pre_i;
    logic [DATA_SIZE-1:0] pre_q;

    logic in_ready;
    logic xfer;
    logic pre_load;
    logic last_pre;
    logic last_pay;

    assign in_ready = en && (state == ST_PAYLOAD);
    assign xfer     = in_ready && s.in_valid;
    assign pre_load = en && ((state == ST_PRE_A) || (state == ST_PRE_B));
    assign last_pre = (cnt == CNT_W'(PREAMBLE_LEN - 1));
    assign last_pay = (cnt == CNT_W'(PAYLOAD_LEN - 1));

    ofdm_preamble_gen #(
        .DATA_SIZE    (DATA_SIZE),
        .PREAMBLE_A_I (PREAMBLE_A_I),
        .PREAMBLE_A_Q (PREAMBLE_A_Q),
        .PREAMBLE_B_I (PREAMBLE_B_I),
        .PREAMBLE_B_Q (PREAMBLE_B_Q),
        .AMP          (AMP)
    ) u_pre (
        .clk   (clk),
        .reset (reset),
        .load  (pre_load),
        .sel_b (state == ST_PRE_B),
        .idx   (~cnt[PRE_IDX_W-1:0]),   // MSB of each mask goes out first
        .pre_i (pre_i),
        .pre_q (pre_q)
    );

`ifdef OFDM_FRAME_TX_GAP_EN
    logic last_gap;
    assign last_gap = (cnt == CNT_W'(GAP_LEN - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            out_valid_r  <= 1'b0;
            out_sel_pre  <= 1'b0;
            pay_i        <= '0;
            pay_q        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            o_frame_done <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_PRE_A;
                            cnt   <= '0;
                        end
                    end
                    ST_PRE_A, ST_PRE_B: begin
                        out_valid_r <= 1'b1;
                        out_sel_pre <= 1'b1;
                        if (last_pre) begin
                            state <= (state == ST_PRE_A) ? ST_PRE_B : ST_PAYLOAD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_PAYLOAD: begin
                        if (xfer) begin
                            out_valid_r <= 1'b1;
                            out_sel_pre <= 1'b0;
                            pay_i       <= s.in_data_i;
                            pay_q       <= s.in_data_q;
                            if (last_pay) begin
                                cnt <= '0;
`ifdef OFDM_FRAME_TX_GAP_EN
                                state <= ST_GAP;
`else
                                state        <= ST_IDLE;
                                o_frame_done <= 1'b1;
`endif
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef OFDM_FRAME_TX_GAP_EN
                    ST_GAP: begin
                        out_valid_r <= 1'b1;
                        out_sel_pre <= 1'b0;
                        pay_i       <= '0;
                        pay_q       <= '0;
                        if (last_gap) begin
                            state        <= ST_IDLE;
                            cnt          <= '0;
                            o_frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign s.in_ready   = in_ready;
    assign s.out_valid  = out_valid_r;
    assign s.out_data_i = out_sel_pre ? pre_i : pay_i;
    assign s.out_data_q = out_sel_pre ? pre_q : pay_q;

endmodule

// File: doc/ofdm_frame_tx.md
# ofdm_frame_tx

Transmit-side OFDM frame builder: on a start request it emits preamble A (256 samples), then preamble B (256 samples), then a fixed-length payload streamed from an upstream symbol source. Each preamble is a ±AMP I/Q sequence defined by 256-bit masks, the same sequences the receive-side preamble correlators search for. The block sits between the IFFT/cyclic-prefix stage and the DAC interface. It produces one sample per enabled clock.

## Interface
- DATA_SIZE, 16, I/Q sample width (signed, two's complement)
- PREAMBLE_A_I / PREAMBLE_A_Q, 256-bit, preamble A sign masks (1 → +AMP, 0 → −AMP)
- PREAMBLE_B_I / PREAMBLE_B_Q, 256-bit, preamble B sign masks
- AMP, 2^(DATA_SIZE-2), preamble magnitude
- PAYLOAD_LEN, 1024, payload samples per frame (≥1)
- GAP_LEN, 64, zero samples after payload (used only with the gap macro)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global clock enable; all state advances only when en=1
- start  in  1  frame request, sampled in IDLE with en=1
- in_valid  in  1  payload sample available
- in_ready  out  1  payload sample accepted this cycle (in_valid & in_ready)
- in_data_i / in_data_q  in  DATA_SIZE  payload sample
- out_valid  out  1  out_data_* is a valid sample
- out_data_i / out_data_q  out  DATA_SIZE  transmitted sample
- busy  out  1  state ≠ IDLE
- o_frame_done  out  1  one-cycle pulse with the last frame sample

## Operation
- States: IDLE, PRE_A, PRE_B, PAYLOAD, GAP (GAP exists only with the gap macro). Counter cnt has width clog2(max(256, PAYLOAD_LEN, GAP_LEN)).
- IDLE: if en & start, go to PRE_A with cnt=0. Otherwise hold.
- PRE_A: on each en cycle, register the sample for mask bit index 255−cnt. The MSB is transmitted first. Increment cnt. At cnt=255, go to PRE_B with cnt=0.
- PRE_B: same as PRE_A using the B masks. At cnt=255, go to PAYLOAD with cnt=0.
- PAYLOAD: in_ready = en & (state==PAYLOAD), combinational. On a transfer, register the input sample to the output and increment cnt. With in_valid=0, out_valid=0 next cycle and cnt holds (a stall; no zero stuffing). The transfer at cnt=PAYLOAD_LEN−1 ends the payload.
- Sample value: bit=1 → +AMP, bit=0 → −AMP, sign-extended to DATA_SIZE. I and Q are independent.
- start outside IDLE is ignored. There is no queueing.
- en=0: state and cnt hold, in_ready=0, and out_valid clears at the next edge. Data outputs hold their last value.

## Timing
- Reset (async): state=IDLE, cnt=0, out_valid=0, out_data_i/q=0, busy=0, o_frame_done=0. in_ready=0 combinationally.
- Reset mid-frame aborts the frame immediately. There is no partial-frame completion.
- Latency: start accepted at edge E0 → A[255] on the outputs after edge E1. The output register is a 1-clock pipeline.
- Payload latency: a sample transferred at edge Ek appears on out_data after Ek.
- Continuous frame with en=1 and no stalls: 512+PAYLOAD_LEN consecutive out_valid cycles.
- busy rises at the edge start is accepted. It falls at the edge after which the last sample is presented (state returns to IDLE).
- A new start is accepted in the cycle busy is low. This gives a one-idle-cycle minimum between frames without the gap macro.
- o_frame_done is asserted together with out_valid on the final frame sample: the last payload sample, or the last gap sample when the gap macro is defined.

## Configuration
- OFDM_FRAME_TX_GAP_EN defined:
  - After PAYLOAD, enter GAP for GAP_LEN en-cycles.
  - Output out_valid=1 with data 0 during GAP. in_ready=0.
  - o_frame_done fires on the last gap sample, then the block returns to IDLE.
- OFDM_FRAME_TX_GAP_EN undefined:
  - The GAP state, its counter compare and GAP_LEN logic are absent.
  - PAYLOAD goes directly to IDLE, and o_frame_done fires on the last payload sample.

## Structure
- Shared package ofdm_pkg holds:
  - the state enum;
  - PREAMBLE_LEN=256;
  - the default preamble mask constants, so the RX correlators and this block reference one definition.
- Sub-module ofdm_preamble_gen selects the mask (A/B) and index, and returns the registered ±AMP I/Q pair.
- The top level holds the FSM, the counter and the payload mux.

## Test plan
- Preamble: default masks, en=1, pulse start → 512 out_valid samples.
  - Sample 0 is I=sign(A_I[255])·AMP and Q=sign(A_Q[255])·AMP.
  - Sample 256 uses B[255].
  - All values are ±16384 (DATA_SIZE=16).
- Payload passthrough: PAYLOAD_LEN=8, feed a ramp I=1..8, Q=−1..−8 → outputs 513–520 match, and o_frame_done is high only on the 520th sample.
- Underflow: drop in_valid for 3 cycles mid-payload → exactly 3 out_valid=0 cycles, no lost or duplicated samples, and cnt is unchanged.
- Enable pause: en=0 for 5 cycles during PRE_A → the sequence resumes at the next index, and out_valid is low for 5 cycles.
- Reset/start: assert reset mid-PRE_B → outputs are 0 and busy=0 immediately. A start pulsed while busy is ignored, so the frame count is unchanged.
- Gap (OFDM_FRAME_TX_GAP_EN, GAP_LEN=4): after the last payload sample, 4 zero samples with out_valid=1 → o_frame_done is on the 4th zero sample, then busy=0.
